// File: rtl/cmd_tx_pkg.sv
// Shared types and constants for the RS422 command transmit scheduler.
package cmd_tx_pkg;

  localparam int unsigned NUM_SRC = 5;
  localparam int unsigned LEN_W   = 8;
  localparam int unsigned GAP_W   = 16;

  // One-hot source codes, bit position equals request/grant index.
  localparam logic [NUM_SRC-1:0] SRC_PLATFORM     = 5'b00001;
  localparam logic [NUM_SRC-1:0] SRC_DATA_INJ     = 5'b00010;
  localparam logic [NUM_SRC-1:0] SRC_PRE_SHUTDOWN = 5'b00100;
  localparam logic [NUM_SRC-1:0] SRC_TIMECODE     = 5'b01000;
  localparam logic [NUM_SRC-1:0] SRC_HK           = 5'b10000;

  // Fixed frame lengths in bytes per command source.
  localparam logic [LEN_W-1:0] LEN_PLATFORM     = 8'd13;
  localparam logic [LEN_W-1:0] LEN_DATA_INJ     = 8'd9;
  localparam logic [LEN_W-1:0] LEN_PRE_SHUTDOWN = 8'd9;
  localparam logic [LEN_W-1:0] LEN_TIMECODE     = 8'd25;
  localparam logic [LEN_W-1:0] LEN_HK           = 8'd53;
  localparam logic [LEN_W-1:0] LEN_DEFAULT      = 8'd53;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FETCH,
    ST_SEND,
    ST_GAP
  } state_e;

  // Fixed priority: pre-shutdown, timecode, platform, data injection, HK.
  function automatic logic [NUM_SRC-1:0] prio_pick(input logic [NUM_SRC-1:0] req);
    logic [NUM_SRC-1:0] pick;
    pick = '0;
    if ((req & SRC_PRE_SHUTDOWN) != '0)  pick = SRC_PRE_SHUTDOWN;
    else if ((req & SRC_TIMECODE) != '0) pick = SRC_TIMECODE;
    else if ((req & SRC_PLATFORM) != '0) pick = SRC_PLATFORM;
    else if ((req & SRC_DATA_INJ) != '0) pick = SRC_DATA_INJ;
    else if ((req & SRC_HK) != '0)       pick = SRC_HK;
    return pick;
  endfunction

endpackage

// File: rtl/cmd_frame_len.sv
// Registered one-hot grant to frame length lookup, one cycle of latency.
module cmd_frame_len
  import cmd_tx_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic [NUM_SRC-1:0] gnt_i,
  output logic [LEN_W-1:0]   frame_len_o
);

  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] len_d;

  // Select the length for the granted source when asked to load.
  always_comb begin
    len_d = len_q;
    if (load_i) begin
      case (gnt_i)
        SRC_PLATFORM:     len_d = LEN_PLATFORM;
        SRC_DATA_INJ:     len_d = LEN_DATA_INJ;
        SRC_PRE_SHUTDOWN: len_d = LEN_PRE_SHUTDOWN;
        SRC_TIMECODE:     len_d = LEN_TIMECODE;
        SRC_HK:           len_d = LEN_HK;
        default:          len_d = LEN_DEFAULT;
      endcase
    end
  end

  // Length register, returns to the default length on reset.
  always_ff @(posedge clk) begin
    if (rst) len_q <= LEN_DEFAULT;
    else     len_q <= len_d;
  end

  assign frame_len_o = len_q;

endmodule

// File: rtl/cmd_tx_scheduler.sv
// Fixed-priority scheduler sharing one UART byte transmitter between five
// command sources: grant, fetch frame bytes, stream them, then hold a gap.
module cmd_tx_scheduler
  import cmd_tx_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] req,
  output logic [NUM_SRC-1:0] gnt,
  output logic [NUM_SRC-1:0] done,
  output logic               rd_en,
  output logic [LEN_W-1:0]   rd_addr,
  input  logic [7:0]         rd_data,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic [LEN_W-1:0]   frame_len,
  output logic               busy
);

  state_e             state_q, state_d;
  logic [NUM_SRC-1:0] gnt_q, gnt_d;
  logic [NUM_SRC-1:0] done_q, done_d;
  logic               rd_en_q, rd_en_d;
  logic [LEN_W-1:0]   rd_addr_q, rd_addr_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               tx_valid_q, tx_valid_d;
  logic               busy_q, busy_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic               len_load_c;
  logic [LEN_W-1:0]   frame_len_w;
  logic [LEN_W-1:0]   last_idx_c;

  // Frame length is latched from the grant while in LOAD.
  cmd_frame_len u_frame_len (
    .clk         (clk),
    .rst         (rst),
    .load_i      (len_load_c),
    .gnt_i       (gnt_q),
    .frame_len_o (frame_len_w)
  );

  assign last_idx_c = frame_len_w - LEN_W'(1);

  // Next-state and next-output logic for the grant/fetch/send/gap sequence.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    done_d     = '0;
    rd_en_d    = 1'b0;
    rd_addr_d  = rd_addr_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    gap_cnt_d  = gap_cnt_q;
    len_load_c = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (req != '0) begin
          gnt_d     = prio_pick(req);
          rd_en_d   = 1'b1;
          rd_addr_d = '0;
          state_d   = ST_LOAD;
        end
      end
      ST_LOAD: begin
        len_load_c = 1'b1;
        state_d    = ST_FETCH;
      end
      ST_FETCH: begin
        tx_data_d  = rd_data;
        tx_valid_d = 1'b1;
        state_d    = ST_SEND;
      end
      ST_SEND: begin
        // tx_data/tx_valid hold until the UART takes the byte.
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          if (rd_addr_q == last_idx_c) begin
            done_d    = gnt_q;
            gnt_d     = '0;
            gap_cnt_d = '0;
            state_d   = ST_GAP;
          end else begin
            rd_addr_d = rd_addr_q + LEN_W'(1);
            rd_en_d   = 1'b1;
            state_d   = ST_FETCH;
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      gnt_q      <= '0;
      done_q     <= '0;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      gap_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      rd_en_q    <= rd_en_d;
      rd_addr_q  <= rd_addr_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      gap_cnt_q  <= gap_cnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign rd_en     = rd_en_q;
  assign rd_addr   = rd_addr_q;
  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign busy      = busy_q;
  assign frame_len = frame_len_w;

endmodule

// File: tb/tb_cmd_tx_scheduler.sv
// Self-checking bench for cmd_tx_scheduler: directed scenarios plus random
// traffic, every cycle compared against a frame-timeline reference model.
module tb_cmd_tx_scheduler;

  localparam int unsigned G = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] req = '0;
  logic [4:0] gnt, done;
  logic       rd_en;
  logic [7:0] rd_addr, rd_data, tx_data, frame_len;
  logic       tx_valid, busy;
  logic       tx_ready = 1'b1;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int acc_cnt = 0;
  int done_cnt = 0;
  logic model_ok = 1'b0;

  logic [7:0] mem [5][256];

  cmd_tx_scheduler #(.GAP_CYCLES(G)) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .frame_len(frame_len), .busy(busy)
  );

  always #5 clk = ~clk;

  // Source buffers: the granted buffer presents the addressed byte.
  always_comb begin
    rd_data = 8'h00;
    for (int i = 0; i < 5; i++) if (gnt[i]) rd_data = mem[i][rd_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: priority order and length table by source index.
  function automatic int pick_src(input logic [4:0] r);
    int order [5] = '{2, 3, 0, 1, 4};
    for (int i = 0; i < 5; i++) if (r[order[i]]) return order[i];
    return -1;
  endfunction

  function automatic int len_of(input int s);
    int lens [5] = '{13, 9, 9, 25, 53};
    return lens[s];
  endfunction

  // Model state: mode 0 idle, 1 in frame, 2 gap. In a frame, slot t counts
  // non-stalled cycles since the grant: t=0 grant cycle, odd t fetches byte
  // (t-1)/2, even t>=2 offers byte t/2-1 to the UART.
  int m_mode = 0, m_src = 0, m_len = 53, m_t = 0, m_g = 0;
  logic [4:0] e_gnt, e_done;
  logic       e_rd_en, e_tx_valid, e_busy;
  logic [7:0] e_rd_addr, e_tx_data, e_len;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      model_ok = 1'b1;
      m_mode = 0;
      e_gnt = '0; e_done = '0; e_rd_en = 1'b0; e_rd_addr = '0;
      e_tx_data = '0; e_tx_valid = 1'b0; e_len = 8'd53; e_busy = 1'b0;
    end else if (model_ok) begin
      e_done = '0;
      case (m_mode)
        0: if (req != '0) begin
             m_src = pick_src(req); m_len = len_of(m_src); m_t = 0; m_mode = 1;
           end
        1: if (m_t >= 2 && (m_t % 2) == 0) begin
             if (tx_ready) begin
               if (m_t / 2 - 1 == m_len - 1) begin
                 m_mode = 2; m_g = 0; e_done = 5'(1 << m_src);
               end else m_t++;
             end
           end else m_t++;
        default: if (m_g == int'(G) - 1) m_mode = 0; else m_g++;
      endcase
      case (m_mode)
        0: begin e_gnt = '0; e_busy = 1'b0; e_rd_en = 1'b0; e_tx_valid = 1'b0; end
        1: begin
          e_gnt = 5'(1 << m_src); e_busy = 1'b1;
          if (m_t == 0) begin
            e_rd_en = 1'b1; e_rd_addr = '0; e_tx_valid = 1'b0;
          end else if ((m_t % 2) == 1) begin
            e_rd_en = ((m_t - 1) / 2) > 0; e_rd_addr = 8'((m_t - 1) / 2);
            e_tx_valid = 1'b0; e_len = 8'(m_len);
          end else begin
            e_rd_en = 1'b0; e_rd_addr = 8'(m_t / 2 - 1); e_tx_valid = 1'b1;
            e_tx_data = mem[m_src][m_t / 2 - 1];
          end
        end
        default: begin e_gnt = '0; e_busy = 1'b1; e_rd_en = 1'b0; e_tx_valid = 1'b0; end
      endcase
    end
  end

  // Compare process plus accept/done counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (tx_valid && tx_ready) acc_cnt++;
    if (done != '0) done_cnt++;
    if (model_ok) begin
      chk("gnt", 32'(gnt), 32'(e_gnt));
      chk("done", 32'(done), 32'(e_done));
      chk("rd_en", 32'(rd_en), 32'(e_rd_en));
      chk("rd_addr", 32'(rd_addr), 32'(e_rd_addr));
      chk("tx_valid", 32'(tx_valid), 32'(e_tx_valid));
      chk("tx_data", 32'(tx_data), 32'(e_tx_data));
      chk("frame_len", 32'(frame_len), 32'(e_len));
      chk("busy", 32'(busy), 32'(e_busy));
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 400) begin tick(); n++; end
    chk(name, 32'(busy), 32'd0);
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (done == '0 && n < budget) begin tick(); n++; end
    chk(name, 32'(done != '0), 32'd1);
  endtask

  initial begin
    int n0, a0, d0, ng, n;
    logic [4:0] got [5];
    logic [4:0] exp_order [5] = '{5'b00100, 5'b01000, 5'b00001, 5'b00010, 5'b10000};

    for (int s = 0; s < 5; s++)
      for (int a = 0; a < 256; a++) mem[s][a] = 8'($urandom);

    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    chk("reset_frame_len", 32'(frame_len), 32'd53);
    chk("reset_gnt", 32'(gnt), 32'd0);
    tick();

    // Platform alone: done exactly 28 cycles after req seen, 13 bytes.
    req = 5'b00001; n0 = cyc; a0 = acc_cnt;
    tick();
    chk("plat_gnt", 32'(gnt), 32'h01);
    chk("plat_rd_en", 32'(rd_en), 32'd1);
    req = '0;
    wait_done("plat_done_seen", 100);
    chk("plat_done_lat", 32'(cyc - n0), 32'd28);
    chk("plat_done_val", 32'(done), 32'h01);
    chk("plat_bytes", 32'(acc_cnt - a0), 32'd13);
    tick();
    chk("plat_busy_gap", 32'(busy), 32'd1);
    wait_idle("plat_idle");

    // All five requesting: each dropped once granted.
    for (int i = 0; i < 5; i++) got[i] = '0;
    req = 5'b11111; ng = 0; n = 0;
    while (ng < 5 && n < 3000) begin
      tick(); n++;
      if (gnt != '0 && (req & gnt) != '0) begin
        got[ng] = gnt; ng++; req = req & ~gnt;
      end
    end
    for (int i = 0; i < 5; i++) chk($sformatf("order_%0d", i), 32'(got[i]), 32'(exp_order[i]));
    req = '0;
    wait_idle("order_idle");

    // HK with tx_ready toggling: stalls hold the byte, one done.
    tick();
    req = 5'b10000; a0 = acc_cnt; d0 = done_cnt;
    tick(); req = '0; n = 0;
    while (done == '0 && n < 400) begin tx_ready = ~tx_ready; tick(); n++; end
    tx_ready = 1'b1;
    chk("stall_done", 32'(done), 32'h10);
    repeat (3) tick();
    chk("stall_done_once", 32'(done_cnt - d0), 32'd1);
    chk("stall_bytes", 32'(acc_cnt - a0), 32'd53);
    wait_idle("stall_idle");

    // Pre-shutdown arrives during HK byte 10: no preemption.
    req = 5'b10000; tick(); req = '0; n = 0;
    while (!(gnt == 5'b10000 && rd_addr == 8'd10) && n < 200) begin tick(); n++; end
    req = 5'b00100;
    wait_done("preempt_done_seen", 300);
    chk("preempt_hk_done", 32'(done), 32'h10);
    n = 0;
    while (gnt == '0 && n < 100) begin tick(); n++; end
    chk("preempt_next_gnt", 32'(gnt), 32'h04);
    req = '0;
    wait_idle("preempt_idle");

    // Reset at byte 5 of a timecode frame.
    req = 5'b01000; tick(); req = '0; n = 0; d0 = done_cnt;
    while (!(rd_addr == 8'd5 && tx_valid) && n < 200) begin tick(); n++; end
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_frame_len", 32'(frame_len), 32'd53);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_no_done", 32'(done_cnt - d0), 32'd0);
    req = 5'b01000; tick();
    chk("rst_restart_gnt", 32'(gnt), 32'h08);
    chk("rst_restart_addr", 32'(rd_addr), 32'd0);
    req = '0;
    wait_idle("rst_idle");

    // HK drops req mid-frame: frame completes.
    req = 5'b10000; a0 = acc_cnt; n = 0;
    while (!(gnt == 5'b10000 && rd_addr == 8'd20) && n < 200) begin tick(); n++; end
    req = '0;
    wait_done("drop_done_seen", 200);
    chk("drop_done", 32'(done), 32'h10);
    chk("drop_bytes", 32'(acc_cnt - a0), 32'd53);
    wait_idle("drop_idle");

    // Random traffic, stalls and occasional resets.
    for (int i = 0; i < 4000; i++) begin
      req      = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'b0;
      tx_ready = ($urandom_range(0, 3) != 0);
      rst      = ($urandom_range(0, 699) == 0);
      tick();
    end
    rst = 1'b0; req = '0; tx_ready = 1'b1;
    repeat (5) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
